// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry skid-free stage with operand forwarding and load-use stall.
// Optional macro ID_EX_FORWARDING_EN enables forwarding; otherwise any RAW dependency stalls.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rs1_addr,
   input  logic [4:0]  in_rs2_addr,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   input  logic [31:0] in_imm,
   input  logic        in_use_imm,
   input  logic [3:0]  in_alu_control,
   input  logic [4:0]  in_rd,
   input  logic        in_reg_write,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic        flush,
   input  logic [31:0] fwd_ex_result,
   input  logic [4:0]  fwd_mem_rd,
   input  logic        fwd_mem_reg_write,
   input  logic [31:0] fwd_mem_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_control,
   output logic [31:0] out_store_data,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write
);

   logic        hazard;
   logic        accept;
   logic        rs2_used;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;

   // rs2 is only a true source when it feeds the ALU or supplies store data
   assign rs2_used = !in_use_imm || in_mem_write;

`ifdef ID_EX_FORWARDING_EN
   logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
   logic ex_can_fwd;

   // A held load has no result yet, so it is never an execute-stage forwarding source
   assign ex_can_fwd  = out_valid && out_reg_write && !out_mem_read;
   assign ex_hit_rs1  = ex_can_fwd && (in_rs1_addr != 5'd0) && (out_rd == in_rs1_addr);
   assign ex_hit_rs2  = ex_can_fwd && (in_rs2_addr != 5'd0) && (out_rd == in_rs2_addr);
   assign mem_hit_rs1 = fwd_mem_reg_write && (in_rs1_addr != 5'd0) && (fwd_mem_rd == in_rs1_addr);
   assign mem_hit_rs2 = fwd_mem_reg_write && (in_rs2_addr != 5'd0) && (fwd_mem_rd == in_rs2_addr);

   always_comb begin
      rs1_val = in_rs1_data;
      rs2_val = in_rs2_data;
      if (ex_hit_rs1)       rs1_val = fwd_ex_result;
      else if (mem_hit_rs1) rs1_val = fwd_mem_result;
      if (ex_hit_rs2)       rs2_val = fwd_ex_result;
      else if (mem_hit_rs2) rs2_val = fwd_mem_result;
   end

   assign hazard = in_valid && out_valid && out_mem_read && (out_rd != 5'd0) &&
                   ((out_rd == in_rs1_addr) || ((out_rd == in_rs2_addr) && rs2_used));
`else
   logic ex_raw, mem_raw;
   logic unused_fwd_data;

   assign unused_fwd_data = ^{fwd_ex_result, fwd_mem_result};
   assign rs1_val = in_rs1_data;
   assign rs2_val = in_rs2_data;

   // Without forwarding, any pending writer of a source register blocks issue
   assign ex_raw  = out_valid && out_reg_write && (out_rd != 5'd0) &&
                    ((out_rd == in_rs1_addr) || ((out_rd == in_rs2_addr) && rs2_used));
   assign mem_raw = fwd_mem_reg_write && (fwd_mem_rd != 5'd0) &&
                    ((fwd_mem_rd == in_rs1_addr) || ((fwd_mem_rd == in_rs2_addr) && rs2_used));
   assign hazard  = in_valid && (ex_raw || mem_raw);
`endif

   assign in_ready = !rst_n || flush || ((!out_valid || out_ready) && !hazard);
   assign accept   = in_valid && in_ready;

   // Flush beats accept; a drained entry leaves only out_valid cleared
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         alu_a          <= 32'd0;
         alu_b          <= 32'd0;
         out_store_data <= 32'd0;
         alu_control    <= 4'd0;
         out_rd         <= 5'd0;
         out_reg_write  <= 1'b0;
         out_mem_read   <= 1'b0;
         out_mem_write  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid      <= 1'b1;
         alu_a          <= rs1_val;
         alu_b          <= in_use_imm ? in_imm : rs2_val;
         out_store_data <= rs2_val;
         alu_control    <= in_alu_control;
         out_rd         <= in_rd;
         out_reg_write  <= in_reg_write;
         out_mem_read   <= in_mem_read;
         out_mem_write  <= in_mem_write;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by randomized traffic.
// The reference model tracks which instruction occupies the stage and what value each source should see.
module tb_id_ex_stage;

   typedef struct packed {
      logic        rst_n;
      logic        in_valid;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] rs1_d;
      logic [31:0] rs2_d;
      logic [31:0] imm;
      logic        use_imm;
      logic [3:0]  ctl;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        flush;
      logic [31:0] ex_res;
      logic [4:0]  mem_rd;
      logic        mem_we;
      logic [31:0] mem_res;
      logic        out_ready;
   } stim_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [3:0]  ctl;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs1_addr, in_rs2_addr;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm;
   logic        in_use_imm;
   logic [3:0]  in_alu_control;
   logic [4:0]  in_rd;
   logic        in_reg_write, in_mem_read, in_mem_write;
   logic        flush;
   logic [31:0] fwd_ex_result;
   logic [4:0]  fwd_mem_rd;
   logic        fwd_mem_reg_write;
   logic [31:0] fwd_mem_result;
   logic        out_valid, out_ready;
   logic [31:0] alu_a, alu_b, out_store_data;
   logic [3:0]  alu_control;
   logic [4:0]  out_rd;
   logic        out_reg_write, out_mem_read, out_mem_write;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   logic m_valid = 1'b0;
   exp_t m_e = '0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm),
      .in_alu_control(in_alu_control), .in_rd(in_rd),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .flush(flush),
      .fwd_ex_result(fwd_ex_result),
      .fwd_mem_rd(fwd_mem_rd), .fwd_mem_reg_write(fwd_mem_reg_write), .fwd_mem_result(fwd_mem_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .out_store_data(out_store_data), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rst_n = 1'b1;
      s.out_ready = 1'b1;
      return s;
   endfunction

   // Value the instruction should see for register x: newest producer that has a result, else the register file
   function automatic logic [31:0] model_src(input logic [4:0] x, input logic [31:0] rf, input stim_t s);
`ifdef ID_EX_FORWARDING_EN
      if (x == 5'd0) return rf;
      if (m_valid && m_e.rw && !m_e.mr && m_e.rd == x) return s.ex_res;
      if (s.mem_we && s.mem_rd == x) return s.mem_res;
`endif
      return rf;
   endfunction

   function automatic logic reads_reg(input logic [4:0] r, input stim_t s);
      return (r != 5'd0) && ((r == s.rs1) || ((r == s.rs2) && (!s.use_imm || s.mw)));
   endfunction

   function automatic logic model_stall(input stim_t s);
      if (!s.in_valid) return 1'b0;
`ifdef ID_EX_FORWARDING_EN
      return m_valid && m_e.mr && reads_reg(m_e.rd, s);
`else
      return (m_valid && m_e.rw && reads_reg(m_e.rd, s)) || (s.mem_we && reads_reg(s.mem_rd, s));
`endif
   endfunction

   task automatic applyStimulus(input stim_t s);
      logic exp_ready;
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = s.rst_n; in_valid = s.in_valid;
      in_rs1_addr = s.rs1; in_rs2_addr = s.rs2; in_rs1_data = s.rs1_d; in_rs2_data = s.rs2_d;
      in_imm = s.imm; in_use_imm = s.use_imm; in_alu_control = s.ctl; in_rd = s.rd;
      in_reg_write = s.rw; in_mem_read = s.mr; in_mem_write = s.mw; flush = s.flush;
      fwd_ex_result = s.ex_res; fwd_mem_rd = s.mem_rd; fwd_mem_reg_write = s.mem_we;
      fwd_mem_result = s.mem_res; out_ready = s.out_ready;
      @(negedge clk);
      #1;
      exp_ready = !s.rst_n || s.flush || ((!m_valid || s.out_ready) && !model_stall(s));
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (!s.rst_n || s.flush) begin
         m_valid = 1'b0;
         exp_q.delete();
      end else if (s.in_valid && exp_ready) begin
         e.a   = model_src(s.rs1, s.rs1_d, s);
         e.sd  = model_src(s.rs2, s.rs2_d, s);
         e.b   = s.use_imm ? s.imm : e.sd;
         e.ctl = s.ctl; e.rd = s.rd; e.rw = s.rw; e.mr = s.mr; e.mw = s.mw;
         m_e = e;
         m_valid = 1'b1;
         exp_q.push_back(e);
      end else if (m_valid && s.out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   // Monitor: whenever an entry is presented it must match the oldest expected entry; it retires on out_ready
   always @(negedge clk) begin
      exp_t act;
      if (out_valid === 1'b1) begin
         act = {alu_a, alu_b, out_store_data, alu_control, out_rd, out_reg_write, out_mem_read, out_mem_write};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_output: got 0x%027h expected no valid entry", act);
         end else begin
            if (act !== exp_q[0]) begin
               bad++;
               $display("[TB] FAIL out_fields: got 0x%027h expected 0x%027h", act, exp_q[0]);
            end
            if (out_ready === 1'b1) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      stim_t s;
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
      in_use_imm = 1'b0; in_alu_control = '0; in_rd = '0;
      in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
      fwd_ex_result = '0; fwd_mem_rd = '0; fwd_mem_reg_write = 1'b0; fwd_mem_result = '0;

      // Reset, including a beat offered while reset is asserted
      s = idle(); s.rst_n = 1'b0;
      applyStimulus(s);
      s.in_valid = 1'b1; s.rd = 5'd3; s.rw = 1'b1; s.rs1_d = 32'hABCD;
      applyStimulus(s);
      checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(idle());
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_alu_a", alu_a, 32'd0);
      checkOutput("rst_alu_b", alu_b, 32'd0);
      checkOutput("rst_store_data", out_store_data, 32'd0);
      checkOutput("rst_alu_control", {28'd0, alu_control}, 32'd0);
      checkOutput("rst_out_rd", {27'd0, out_rd}, 32'd0);
      checkOutput("rst_ctrl_bits", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'd0);

      // Basic add followed by a dependent instruction
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd1; s.rs1_d = 32'd10; s.rs2 = 5'd2; s.rs2_d = 32'd3;
      s.rd = 5'd5; s.rw = 1'b1;
      applyStimulus(s);
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd5; s.rs1_d = 32'd99; s.rd = 5'd6; s.rw = 1'b1;
      s.ex_res = 32'd13;
      applyStimulus(s);
      checkOutput("add_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("add_alu_a", alu_a, 32'd10);
      checkOutput("add_alu_b", alu_b, 32'd3);
      checkOutput("add_ctl", {28'd0, alu_control}, 32'd0);
`ifdef ID_EX_FORWARDING_EN
      checkOutput("b2b_ready", {31'd0, in_ready}, 32'd1);
`endif
      applyStimulus(idle());
`ifdef ID_EX_FORWARDING_EN
      checkOutput("b2b_fwd_alu_a", alu_a, 32'd13);
`endif
      applyStimulus(idle());

      // Load followed by a consumer of the loaded register
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd1; s.rs1_d = 32'h100; s.use_imm = 1'b1; s.imm = 32'd4;
      s.rd = 5'd7; s.rw = 1'b1; s.mr = 1'b1;
      applyStimulus(s);
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd3; s.rs1_d = 32'd1; s.rs2 = 5'd7; s.rs2_d = 32'h77;
      s.rd = 5'd8; s.rw = 1'b1; s.ctl = 4'd1;
      applyStimulus(s);
`ifdef ID_EX_FORWARDING_EN
      checkOutput("load_use_stall", {31'd0, in_ready}, 32'd0);
`endif
      s.mem_rd = 5'd7; s.mem_we = 1'b1; s.mem_res = 32'h55;
      applyStimulus(s);
      checkOutput("load_use_bubble", {31'd0, out_valid}, 32'd0);
`ifdef ID_EX_FORWARDING_EN
      checkOutput("load_use_resume", {31'd0, in_ready}, 32'd1);
`endif
      applyStimulus(idle());
`ifdef ID_EX_FORWARDING_EN
      checkOutput("load_use_alu_b", alu_b, 32'h55);
`endif
      applyStimulus(idle());
      applyStimulus(idle());

      // Downstream back-pressure for three cycles
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd4; s.rs1_d = 32'h44; s.rd = 5'd9; s.rw = 1'b1;
      applyStimulus(s);
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd10; s.rs1_d = 32'hB0B; s.rs2 = 5'd11; s.rs2_d = 32'h11;
      s.rd = 5'd12; s.rw = 1'b1; s.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(s);
         checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
         checkOutput("stall_alu_a", alu_a, 32'h44);
      end
      s.out_ready = 1'b1;
      applyStimulus(s);
      checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(idle());
      checkOutput("release_alu_a", alu_a, 32'hB0B);

      // Flush of held and incoming instruction, then x0 is never forwarded
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd13; s.rs1_d = 32'h13; s.rd = 5'd14; s.rw = 1'b1;
      s.out_ready = 1'b0;
      applyStimulus(s);
      s.flush = 1'b1; s.rd = 5'd15;
      applyStimulus(s);
      checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(idle());
      checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd0; s.rs1_d = 32'h1234; s.rd = 5'd1; s.rw = 1'b1;
      s.mem_rd = 5'd0; s.mem_we = 1'b1; s.mem_res = 32'hDEAD;
      applyStimulus(s);
      applyStimulus(idle());
      checkOutput("x0_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("x0_alu_a", alu_a, 32'h1234);

      // Randomized traffic with a narrow register range to provoke dependencies
      for (int i = 0; i < 800; i++) begin
         s.rst_n     = ($urandom_range(0, 63) != 0);
         s.in_valid  = ($urandom_range(0, 3) != 0);
         s.rs1       = 5'($urandom_range(0, 7));
         s.rs2       = 5'($urandom_range(0, 7));
         s.rs1_d     = $urandom;
         s.rs2_d     = $urandom;
         s.imm       = $urandom;
         s.use_imm   = 1'($urandom_range(0, 1));
         s.ctl       = 4'($urandom_range(0, 15));
         s.rd        = 5'($urandom_range(0, 7));
         s.rw        = 1'($urandom_range(0, 1));
         s.mr        = 1'($urandom_range(0, 1));
         s.mw        = 1'($urandom_range(0, 1));
         s.flush     = ($urandom_range(0, 15) == 0);
         s.ex_res    = $urandom;
         s.mem_rd    = 5'($urandom_range(0, 7));
         s.mem_we    = 1'($urandom_range(0, 1));
         s.mem_res   = $urandom;
         s.out_ready = ($urandom_range(0, 3) != 0);
         applyStimulus(s);
      end
      for (int i = 0; i < 3; i++) applyStimulus(idle());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
